cp0: RTL and testbench
======================

Name: cp0

Overview:
- System-control coprocessor 0 of the pipelined MIPS core.
- Receives the level-sensitive hardware interrupt lines (bit 0 driven by the external `interrupt` pin) and the internal exception code from the macro-pipeline stage.
- Decides whether to trap, latches EPC/Cause/EXL, and serves mfc0/mtc0/eret.
- Sits beside the M stage; `int_req` flushes the pipeline and redirects fetch to `HANDLER_PC`.

Parameters:
- PRID, 32'h0000_3033, read-only processor ID value returned for CP0 register 15
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address driven on handler_pc

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a1  in  5  mfc0 read register number
- a2  in  5  mtc0 write register number
- din  in  32  mtc0 write data
- we  in  1  mtc0 write enable
- pc  in  32  PC of the M-stage (victim) instruction
- bd  in  1  victim instruction is in a branch delay slot
- exc_code  in  5  pending synchronous exception code, 0 = none
- hw_int  in  6  hardware interrupt lines, level-sensitive; bit 0 = external interrupt pin
- exl_clr  in  1  eret in M stage
- dout  out  32  mfc0 read data
- epc_out  out  32  return address for eret
- int_req  out  1  take trap this cycle
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Registers (all written on posedge clk):
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): bits [1:0] always 0.
  - PrID(15): constant PRID.
- Reset: SR=0, Cause=0, EPC=0. Outputs after reset: dout=0 (for a1≠15), epc_out=0, int_req=0.
- Cause.IP[15:10] <= hw_int every cycle, unconditionally, including during EXL=1.
- Trap decision (combinational, same cycle as inputs):
  - irq = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc = (exc_code != 0) & ~SR.EXL
  - int_req = irq | exc
- Priority: interrupt over exception. ExcCode <= 0 when irq, else exc_code.
- On int_req at posedge:
  - EXL <= 1
  - BD <= bd
  - EPC <= (bd ? pc-4 : pc) & ~3
  - ExcCode per priority rule above.
- Return: exl_clr with int_req=0 → EXL <= 0 at posedge; EPC unchanged.
- mtc0 (we=1, int_req=0):
  - a2=12 writes IM/EXL/IE only.
  - a2=14 writes din & ~3.
  - Cause, PrID and other addresses are ignored.
- Simultaneous events:
  - int_req beats we: mtc0 is discarded.
  - int_req beats exl_clr: EXL stays 1. exl_clr is only reachable when EXL=1, which already forces int_req=0.
  - we to SR with exl_clr: exl_clr wins for EXL; IM/IE take din.
- dout is combinational on a1 from current register state (no write-through):
  - 12 → SR, 13 → Cause, 14 → EPC, 15 → PRID, others → 0.
- epc_out forwards a same-cycle mtc0 to EPC:
  - (we & a2==14 & ~int_req) ? din & ~3 : EPC
  - This lets eret directly after mtc0 EPC return correctly.
- Interrupt level held across several cycles does not re-trap while EXL=1. After eret, if the line is still high and enabled, int_req asserts again in the first cycle with EXL=0.
- Reset mid-handler: all state is cleared; a pending hw_int cannot trap until SR is re-enabled by software.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - Field positions: IM/IP 15:10, EXL 1, IE 0, BD 31, ExcCode 6:2.
- No sub-module: a single flat block.

Test Plan:
- SR init: mtc0 a2=12 din=32'h0000_FC01, then hw_int=6'b000001 with pc=32'h0000_301c, bd=0 → int_req=1 same cycle. Next cycle: EPC=32'h301c, Cause=32'h0000_0400, SR.EXL=1, int_req=0 while hw_int stays high for 6 cycles.
- Delay-slot interrupt: pc=32'h0000_3020, bd=1, hw_int=1 → EPC=32'h301c, Cause[31]=1.
- Simultaneous events: exc_code=12 (OV) with hw_int=1 → ExcCode=0 (interrupt wins). Same with SR.IE=0 → ExcCode=12, int_req=1. Same with SR.EXL=1 → int_req=0.
- mtc0 EPC din=32'h0000_30ae with exl_clr the same cycle → epc_out=32'h30ac immediately; EXL=0 next cycle; hw_int still high → int_req=1 the following cycle.
- Read map: mfc0 a1=15 → PRID; a1=13 with hw_int=6'b100001 → IP bits 15 and 10 set. mtc0 to Cause → no change. a1=7 → 0.
- Reset asserted while EXL=1 and hw_int=1 → next cycle SR=0, EPC=0, int_req=0 until software sets IE and IM.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0 shared definitions: register numbers, exception codes, field positions.
// Pure constants; no logic, no latency.
// Imported by the interface, the cp0 block and its testbench.
package cp0_pkg;

    // CP0 register numbers as seen by mfc0/mtc0
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Field positions (SR.IM and Cause.IP share 15:10)
    localparam int IM_HI  = 15;
    localparam int IM_LO  = 10;
    localparam int EXL_B  = 1;
    localparam int IE_B   = 0;
    localparam int BD_B   = 31;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

endpackage

// File: rtl/cp0_if.sv
// cp0 pipeline-side bus: mfc0/mtc0 access, victim info, trap request and redirect.
// Wires only; timing is defined by cp0 (reads and trap decision are combinational).
// No backpressure: the pipeline must honour int_req in the same cycle.
interface cp0_if;
    import cp0_pkg::*;

    logic [4:0]  a1;          // mfc0 read register number
    logic [4:0]  a2;          // mtc0 write register number
    logic [31:0] din;         // mtc0 write data
    logic        we;          // mtc0 write enable
    logic [31:0] pc;          // M-stage (victim) PC
    logic        bd;          // victim is in a branch delay slot
    logic [4:0]  exc_code;    // pending synchronous exception, 0 = none
    logic [5:0]  hw_int;      // level-sensitive interrupt lines
    logic        exl_clr;     // eret in M stage
    logic [31:0] dout;        // mfc0 read data
    logic [31:0] epc_out;     // eret return address (mtc0 EPC forwarded)
    logic        int_req;     // take trap this cycle
    logic [31:0] handler_pc;  // trap entry address

    // pipeline side
    modport master (
        output a1, a2, din, we, pc, bd, exc_code, hw_int, exl_clr,
        input  dout, epc_out, int_req, handler_pc
    );

    // coprocessor side
    modport slave (
        input  a1, a2, din, we, pc, bd, exc_code, hw_int, exl_clr,
        output dout, epc_out, int_req, handler_pc
    );

endinterface

// File: rtl/cp0.sv
// MIPS coprocessor 0: trap decision, SR/Cause/EPC/PrID state, mfc0/mtc0/eret.
// Trap decision and reads are combinational; state updates at the next posedge clk.
// No backpressure: a trap discards a same-cycle mtc0; eret cannot coincide with a trap.
// Ports: clk, reset (sync, active-high), bus (cp0_if.slave).
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h0000_3033,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic   clk,
    input  logic   reset,
    cp0_if.slave   bus
);

    // architectural state
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        irq;
    logic        exc;
    logic        trap;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // EXL masks both sources, so a held interrupt level cannot re-trap inside the handler
    assign irq  = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc  = (bus.exc_code != 5'd0) & ~sr_exl;
    assign trap = irq | exc;

    // a trap in the same cycle wins over a software write
    assign wr_sr  = bus.we & (bus.a2 == CP0_SR)  & ~trap;
    assign wr_epc = bus.we & (bus.a2 == CP0_EPC) & ~trap;

    // a delay-slot victim restarts at its branch
    assign victim_pc = (bus.bd ? bus.pc - 32'd4 : bus.pc) & ~32'd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= bus.hw_int;
            if (trap) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.bd;
                cause_exc <= irq ? EXC_INT : bus.exc_code;
                epc       <= victim_pc;
            end else begin
                if (wr_sr) begin
                    sr_im  <= bus.din[IM_HI:IM_LO];
                    sr_exl <= bus.din[EXL_B];
                    sr_ie  <= bus.din[IE_B];
                end
                if (wr_epc)
                    epc <= bus.din & ~32'd3;
                // eret overrides a same-cycle SR write for EXL only
                if (bus.exl_clr)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_val                = '0;
        sr_val[IM_HI:IM_LO]   = sr_im;
        sr_val[EXL_B]         = sr_exl;
        sr_val[IE_B]          = sr_ie;
        cause_val             = '0;
        cause_val[BD_B]       = cause_bd;
        cause_val[IM_HI:IM_LO] = cause_ip;
        cause_val[EXC_HI:EXC_LO] = cause_exc;
    end

    // reads see current state only; no write-through
    always_comb begin
        bus.dout = '0;
        case (bus.a1)
            CP0_SR:    bus.dout = sr_val;
            CP0_CAUSE: bus.dout = cause_val;
            CP0_EPC:   bus.dout = epc;
            CP0_PRID:  bus.dout = PRID;
            default:   bus.dout = '0;
        endcase
    end

    // forwarding lets an eret right behind mtc0 EPC return to the new address
    assign bus.epc_out    = wr_epc ? (bus.din & ~32'd3) : epc;
    assign bus.int_req    = trap;
    assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;
    import cp0_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cp0_if bus();

    cp0 #(
        .PRID       (32'h0000_3033),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; return 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.a1 = a;
        #1;
        check(tag, bus.dout, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.a1 = '0; bus.a2 = '0; bus.din = '0; bus.we = 1'b0;
        bus.pc = '0; bus.bd = 1'b0; bus.exc_code = '0; bus.hw_int = '0;
        bus.exl_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        rd("rst_sr", CP0_SR, 32'h0);
        rd("rst_cause", CP0_CAUSE, 32'h0);
        rd("rst_epc", CP0_EPC, 32'h0);
        check("rst_epc_out", bus.epc_out, 32'h0);
        check("rst_int_req", {31'b0, bus.int_req}, 32'h0);
        check("handler_pc", bus.handler_pc, 32'h0000_4180);

        // SR init then external interrupt
        bus.we = 1'b1; bus.a2 = CP0_SR; bus.din = 32'h0000_FC01;
        tick();
        bus.we = 1'b0;
        rd("sr_init", CP0_SR, 32'h0000_FC01);
        bus.hw_int = 6'b000001; bus.pc = 32'h0000_301c; bus.bd = 1'b0;
        #1;
        check("irq_same_cycle", {31'b0, bus.int_req}, 32'h1);
        tick();
        rd("irq_epc", CP0_EPC, 32'h0000_301c);
        rd("irq_cause", CP0_CAUSE, 32'h0000_0400);
        rd("irq_sr_exl", CP0_SR, 32'h0000_FC03);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("irq_held_no_retrap", {31'b0, bus.int_req}, 32'h0);
            tick();
        end

        // eret, then delay-slot interrupt
        bus.exl_clr = 1'b1;
        tick();
        bus.exl_clr = 1'b0; bus.pc = 32'h0000_3020; bus.bd = 1'b1;
        #1;
        check("retrap_after_eret", {31'b0, bus.int_req}, 32'h1);
        tick();
        rd("bd_epc", CP0_EPC, 32'h0000_301c);
        rd("bd_cause", CP0_CAUSE, 32'h8000_0400);

        // interrupt beats exception
        bus.exl_clr = 1'b1;
        tick();
        bus.exl_clr = 1'b0; bus.pc = 32'h0000_3040; bus.bd = 1'b0;
        bus.exc_code = EXC_OV;
        #1;
        check("irq_exc_req", {31'b0, bus.int_req}, 32'h1);
        tick();
        rd("irq_wins_cause", CP0_CAUSE, 32'h0000_0400);
        rd("irq_wins_epc", CP0_EPC, 32'h0000_3040);
        check("exc_masked_exl", {31'b0, bus.int_req}, 32'h0);

        // IE=0, EXL cleared by software: exception alone traps
        bus.we = 1'b1; bus.a2 = CP0_SR; bus.din = 32'h0000_FC00;
        tick();
        bus.we = 1'b0;
        #1;
        check("exc_ie0_req", {31'b0, bus.int_req}, 32'h1);
        tick();
        rd("exc_ie0_cause", CP0_CAUSE, 32'h0000_0430);
        rd("exc_ie0_sr", CP0_SR, 32'h0000_FC02);
        bus.exc_code = '0;

        // mtc0 EPC together with eret
        bus.we = 1'b1; bus.a2 = CP0_SR; bus.din = 32'h0000_FC03;
        tick();
        bus.a2 = CP0_EPC; bus.din = 32'h0000_30ae; bus.exl_clr = 1'b1;
        #1;
        check("epc_fwd", bus.epc_out, 32'h0000_30ac);
        check("eret_no_req", {31'b0, bus.int_req}, 32'h0);
        tick();
        bus.we = 1'b0; bus.exl_clr = 1'b0; bus.pc = 32'h0000_3100;
        rd("epc_written", CP0_EPC, 32'h0000_30ac);
        rd("exl_cleared", CP0_SR, 32'h0000_FC01);
        check("retrap_first_cycle", {31'b0, bus.int_req}, 32'h1);
        tick();
        bus.hw_int = '0;
        #1;
        check("trap_epc_out", bus.epc_out, 32'h0000_3100);

        // read map
        rd("prid", CP0_PRID, 32'h0000_3033);
        bus.hw_int = 6'b100001;
        tick();
        rd("cause_ip", CP0_CAUSE, 32'h0000_8400);
        bus.we = 1'b1; bus.a2 = CP0_CAUSE; bus.din = 32'hFFFF_FFFF;
        tick();
        bus.we = 1'b0;
        rd("cause_ro", CP0_CAUSE, 32'h0000_8400);
        rd("unmapped", 5'd7, 32'h0);

        // SR write with eret: eret wins EXL
        bus.hw_int = '0;
        bus.we = 1'b1; bus.a2 = CP0_SR; bus.din = 32'h0000_FC03; bus.exl_clr = 1'b1;
        tick();
        bus.we = 1'b0; bus.exl_clr = 1'b0;
        rd("sr_eret_wins", CP0_SR, 32'h0000_FC01);
        check("idle_no_req", {31'b0, bus.int_req}, 32'h0);

        // reset inside a handler
        bus.hw_int = 6'b000001;
        tick();
        rd("pre_rst_exl", CP0_SR, 32'h0000_FC03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("midrst_sr", CP0_SR, 32'h0);
        rd("midrst_epc", CP0_EPC, 32'h0);
        check("midrst_req", {31'b0, bus.int_req}, 32'h0);
        tick(); tick();
        check("midrst_req_held", {31'b0, bus.int_req}, 32'h0);
        bus.we = 1'b1; bus.a2 = CP0_SR; bus.din = 32'h0000_0401;
        tick();
        bus.we = 1'b0;
        #1;
        check("reenable_req", {31'b0, bus.int_req}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
